alba_ctrl: RTL and testbench

Multi-cycle control unit for the albaCore 16-bit processor. It fetches instructions from unified memory, decodes them, and sequences operands through the ALU, register file and memory. It drives the ALU's `a`, `b`, `op`, `imm` and `shamt` inputs and consumes its result `f`. It sits between the external register file, the ALU and the memory port.

---
 rtl/alba_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alba_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alba_ctrl.sv
// rtl/alba_ctrl.sv - multi-cycle fetch/decode/execute control unit for the albaCore 16-bit CPU
// Optional retired-instruction counter built only when ALBA_INSTRET_EN is defined.
module alba_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    input  logic [15:0] rf_a_data,
    input  logic [15:0] rf_b_data,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_imm,
    output logic [3:0]  alu_shamt,
    input  logic [15:0] alu_f,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic [15:0] pc_q;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] result;
    logic        rd_q;
    logic        wr_q;
    logic        we_q;
    logic        halt_q;
    logic [3:0]  opcode;

    assign opcode = ir[15:12];

    // Requests are registered; after reset FETCH spends one cycle raising mem_rd,
    // and an ack seen while no request is up is simply ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            pc_q   <= RESET_PC;
            ir     <= 16'h0000;
            op_a   <= 16'h0000;
            op_b   <= 16'h0000;
            result <= 16'h0000;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            we_q   <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (rd_q && mem_ack) begin
                        ir    <= mem_rdata;
                        pc_q  <= pc_q + 16'h0001;
                        rd_q  <= 1'b0;
                        state <= S_DECODE;
                    end else begin
                        rd_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    op_a <= rf_a_data;
                    op_b <= rf_b_data;
                    if (opcode == 4'hF) begin
                        halt_q <= 1'b1;
                        state  <= S_HALT;
                    end else if (opcode == 4'h8) begin
                        rd_q  <= 1'b1;
                        state <= S_MEM;
                    end else if (opcode == 4'h9) begin
                        wr_q  <= 1'b1;
                        state <= S_MEM;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!opcode[3]) begin
                        result <= alu_f;
                        we_q   <= 1'b1;
                        state  <= S_WB;
                    end else begin
                        // pc already points past the branch, so offsets are relative to pc+1
                        if (opcode == 4'hA && op_a == 16'h0000)
                            pc_q <= pc_q + {{8{ir[7]}}, ir[7:0]};
                        else if (opcode == 4'hB)
                            pc_q <= {pc_q[15:12], ir[11:0]};
                        rd_q  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (rd_q) begin
                            result <= mem_rdata;
                            rd_q   <= 1'b0;
                            we_q   <= 1'b1;
                            state  <= S_WB;
                        end else begin
                            wr_q  <= 1'b0;
                            rd_q  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    we_q  <= 1'b0;
                    rd_q  <= 1'b1;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign mem_addr   = (state == S_MEM) ? op_a : pc_q;
    assign mem_rd     = rd_q;
    assign mem_wr     = wr_q;
    assign mem_wdata  = op_b;
    assign rf_ra_addr = (opcode == 4'hA) ? ir[11:8] : ir[7:4];
    assign rf_rb_addr = ir[3:0];
    assign rf_we      = we_q;
    assign rf_waddr   = ir[11:8];
    assign rf_wdata   = result;
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_op     = ir[14:12];
    assign alu_imm    = ir[7:0];
    assign alu_shamt  = ir[3:0];
    assign pc         = pc_q;
    assign halted     = halt_q;

`ifdef ALBA_INSTRET_EN
    logic [15:0] instret_q;
    logic        retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            S_EXEC:   retire = opcode[3];
            S_MEM:    retire = wr_q && mem_ack;
            S_WB:     retire = 1'b1;
            S_DECODE: retire = (opcode == 4'hF);
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= 16'h0000;
        else if (retire)
            instret_q <= instret_q + 16'h0001;
    end

    assign instret = instret_q;
`else
    assign instret = 16'h0000;
`endif

endmodule

// File: tb/tb_alba_ctrl.sv
// tb/tb_alba_ctrl.sv - directed bench for alba_ctrl with memory, register file and ALU models
// Runs a small program from 0x0010 covering ALU ops, LD with wait states, ST, JMP, BZ and HALT.
module tb_alba_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [15:0] rf_a_data;
    logic [15:0] rf_b_data;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_imm;
    logic [3:0]  alu_shamt;
    logic [15:0] alu_f;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] instret;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [15:0] mem [256];
    logic [15:0] regs [16];
    logic [15:0] st_addr = 16'h0000;
    logic [15:0] st_data = 16'h0000;
    logic [15:0] we_mask;
    logic [15:0] exp_instret;

    alba_ctrl #(.RESET_PC(16'h0010)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .rf_a_data  (rf_a_data),
        .rf_b_data  (rf_b_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_imm    (alu_imm),
        .alu_shamt  (alu_shamt),
        .alu_f      (alu_f),
        .pc         (pc),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Memory responds after ack_delay wait cycles of a held request.
    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ack   = (mem_rd || mem_wr) && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!(mem_rd || mem_wr) || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (mem_wr && mem_ack) begin
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
        if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    assign rf_a_data = regs[rf_ra_addr];
    assign rf_b_data = regs[rf_rb_addr];

    always_comb begin
        alu_f = alu_a ^ alu_b;
        case (alu_op)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a << alu_shamt;
            3'd7: alu_f = {8'h00, alu_imm};
            default: alu_f = alu_a ^ alu_b;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        mem[8'h10] = 16'h7105;
        mem[8'h11] = 16'h7203;
        mem[8'h12] = 16'h0312;
        mem[8'h13] = 16'h7420;
        mem[8'h14] = 16'h8340;
        mem[8'h15] = 16'h7430;
        mem[8'h16] = 16'h7621;
        mem[8'h17] = 16'h8560;
        mem[8'h18] = 16'h9045;
        mem[8'h19] = 16'h7100;
        mem[8'h1A] = 16'hB005;
        mem[8'h04] = 16'h7101;
        mem[8'h05] = 16'hA1FE;
        mem[8'h06] = 16'hF000;
        mem[8'h20] = 16'hBEEF;
        mem[8'h21] = 16'h1234;

        reset = 1'b1;
        tick();
        tick();
        chk("reset_pc", pc, 16'h0010);
        chk("reset_req", {13'b0, mem_rd, mem_wr, rf_we}, 16'h0000);
        chk("reset_halted", {15'b0, halted}, 16'h0000);
        chk("reset_alu_ctl", {1'b0, alu_op, alu_imm, alu_shamt}, 16'h0000);
        chk("reset_instret", instret, 16'h0000);

        reset = 1'b0;
        cyc = 0;
        we_mask = 16'h0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            we_mask[c-1] = rf_we;
            if (c == 1) begin
                chk("first_fetch_rd", {15'b0, mem_rd}, 16'h0001);
                chk("first_fetch_addr", mem_addr, 16'h0010);
            end
            if (c == 3) chk("ldi_alu_ctl", {5'b0, alu_op, alu_imm}, 16'h0705);
            if (c == 11) chk("add_operands", {alu_a[7:0], alu_b[7:0]}, 16'h0503);
        end
        chk("wb_pulse_cycles", we_mask, 16'h0888);
        chk("add_waddr", {12'b0, rf_waddr}, 16'h0003);
        chk("add_wdata", rf_wdata, 16'h0008);

        while (cyc < 18) tick();
        ack_delay = 2;
        for (int c = 19; c <= 21; c++) begin
            tick();
            chk("ld_wait_rd", {15'b0, mem_rd}, 16'h0001);
            chk("ld_wait_addr", mem_addr, 16'h0020);
        end
        tick();
        ack_delay = 0;
        chk("ld_wb_we", {15'b0, rf_we}, 16'h0001);
        chk("ld_wb_data", {rf_waddr, 12'h000} | 16'h0000, 16'h3000);
        chk("ld_wb_value", rf_wdata, 16'hBEEF);
        tick();
        chk("ld_next_fetch", mem_addr, 16'h0015);
        chk("ld_we_dropped", {15'b0, rf_we}, 16'h0000);

        while (cyc < 37) tick();
        chk("st_req", {14'b0, mem_rd, mem_wr}, 16'h0001);
        chk("st_addr_out", mem_addr, 16'h0030);
        chk("st_wdata_out", mem_wdata, 16'h1234);
        tick();
        chk("st_then_fetch", {mem_rd, 15'b0} | mem_addr, 16'h8019);
        chk("st_mem_written", st_data, 16'h1234);

        while (cyc < 45) tick();
        chk("jmp_target", mem_addr, 16'h0005);
        while (cyc < 48) tick();
        chk("bz_taken", mem_addr, 16'h0004);
        while (cyc < 55) tick();
        chk("bz_not_taken", mem_addr, 16'h0006);

        while (cyc < 57) tick();
        for (int c = 0; c < 4; c++) begin
            chk("halt_flag", {15'b0, halted}, 16'h0001);
            chk("halt_no_req", {14'b0, mem_rd, mem_wr}, 16'h0000);
            tick();
        end
`ifdef ALBA_INSTRET_EN
        exp_instret = 16'd15;
`else
        exp_instret = 16'd0;
`endif
        chk("instret_final", instret, exp_instret);

        reset = 1'b1;
        tick();
        chk("rst_from_halt", {14'b0, halted, mem_rd}, 16'h0000);
        chk("rst_pc_again", pc, 16'h0010);
        reset = 1'b0;
        tick();
        chk("refetch_after_reset", {mem_rd, 15'b0} | mem_addr, 16'h8010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
